mb_result_reader: RTL and testbench

MB_RESULT_READER -- requirements
Module: mb_result_reader

---
 rtl/mb_result_reader_if.sv | 30 +++
 rtl/mb_result_reader.sv | 152 +++++++++++++++
 tb/tb_mb_result_reader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mb_result_reader_if.sv
// mb_result_reader_if: result-FIFO read side plus the unpacked macroblock record handshake.
interface mb_result_reader_if;
    logic          fifo_empty;
    logic [1023:0] fifo_dout;
    logic          fifo_rd;
    logic          mb_valid;
    logic          mb_ready;
    logic [9:0]    mb_x;
    logic [9:0]    mb_y;
    logic [4095:0] ac_levels;
    logic [2047:0] uv_levels;
    logic [255:0]  dc_levels;
    logic [31:0]   mode_i16;
    logic [127:0]  mode_i4;
    logic [31:0]   mode_uv;
    logic [31:0]   nz;
    logic [7:0]    mbtype;
    logic [7:0]    skipped;
    logic [31:0]   max_edge;
    modport master (
        input  fifo_empty, fifo_dout, mb_ready,
        output fifo_rd, mb_valid, mb_x, mb_y, ac_levels, uv_levels, dc_levels,
               mode_i16, mode_i4, mode_uv, nz, mbtype, skipped, max_edge
    );
    modport slave (
        output fifo_empty, fifo_dout, mb_ready,
        input  fifo_rd, mb_valid, mb_x, mb_y, ac_levels, uv_levels, dc_levels,
               mode_i16, mode_i4, mode_uv, nz, mbtype, skipped, max_edge
    );
endinterface

// File: rtl/mb_result_reader.sv
// mb_result_reader: reads 7-word macroblock records from the result FIFO and presents them frame-wise.
// Optional reserved-bit check enabled by MB_RESULT_READER_FMT_CHECK_EN.
module mb_result_reader (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [9:0]                w1,
    input  logic [9:0]                h1,
    mb_result_reader_if.master        bus,
    output logic                      done,
    output logic                      fmt_err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [2:0]    r_rd_cnt;
    logic [2:0]    r_cap_cnt;
    logic          r_rd_d;
    logic [9:0]    r_w1;
    logic [9:0]    r_h1;
    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic [4095:0] r_ac;
    logic [2047:0] r_uv;
    logic [255:0]  r_dc;
    logic [31:0]   r_i16;
    logic [127:0]  r_i4;
    logic [31:0]   r_muv;
    logic [31:0]   r_nz;
    logic [7:0]    r_type;
    logic [7:0]    r_skip;
    logic [31:0]   r_edge;
    logic          w_rd;
    logic          w_last;

    assign w_rd   = (r_state == FETCH) && !bus.fifo_empty && (r_rd_cnt < 3'd7);
    assign w_last = (r_x >= r_w1) && (r_y >= r_h1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rd_cnt  <= '0;
            r_cap_cnt <= '0;
            r_rd_d    <= 1'b0;
            r_w1      <= '0;
            r_h1      <= '0;
            r_x       <= '0;
            r_y       <= '0;
        end else begin
            r_rd_d <= w_rd;
            case (r_state)
                IDLE: if (start) begin
                    r_state   <= FETCH;
                    r_rd_cnt  <= '0;
                    r_cap_cnt <= '0;
                    r_x       <= '0;
                    r_y       <= '0;
                    r_w1      <= w1;
                    r_h1      <= h1;
                end
                FETCH: begin
                    if (w_rd) r_rd_cnt <= r_rd_cnt + 3'd1;
                    if (r_rd_d) begin
                        r_cap_cnt <= r_cap_cnt + 3'd1;
                        if (r_cap_cnt == 3'd6) r_state <= HOLD;
                    end
                end
                HOLD: if (bus.mb_ready) begin
                    if (w_last) r_state <= DONE;
                    else begin
                        r_state   <= FETCH;
                        r_rd_cnt  <= '0;
                        r_cap_cnt <= '0;
                        r_x       <= (r_x >= r_w1) ? 10'd0 : r_x + 10'd1;
                        r_y       <= (r_x >= r_w1) ? r_y + 10'd1 : r_y;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Capture slot follows the word returned one cycle after each read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ac   <= '0;
            r_uv   <= '0;
            r_dc   <= '0;
            r_i16  <= '0;
            r_i4   <= '0;
            r_muv  <= '0;
            r_nz   <= '0;
            r_type <= '0;
            r_skip <= '0;
            r_edge <= '0;
        end else if (r_rd_d) begin
            case (r_cap_cnt)
                3'd0: r_ac[1023:0]    <= bus.fifo_dout;
                3'd1: r_ac[2047:1024] <= bus.fifo_dout;
                3'd2: r_ac[3071:2048] <= bus.fifo_dout;
                3'd3: r_ac[4095:3072] <= bus.fifo_dout;
                3'd4: r_uv[1023:0]    <= bus.fifo_dout;
                3'd5: r_uv[2047:1024] <= bus.fifo_dout;
                default: begin
                    r_dc   <= bus.fifo_dout[255:0];
                    r_i16  <= bus.fifo_dout[287:256];
                    r_i4   <= bus.fifo_dout[415:288];
                    r_muv  <= bus.fifo_dout[447:416];
                    r_nz   <= bus.fifo_dout[479:448];
                    r_type <= bus.fifo_dout[903:896];
                    r_skip <= bus.fifo_dout[911:904];
                    r_edge <= bus.fifo_dout[959:928];
                end
            endcase
        end
    end

`ifdef MB_RESULT_READER_FMT_CHECK_EN
    logic r_fmt_err;
    logic w_rsvd;
    assign w_rsvd = (|bus.fifo_dout[895:480]) | (|bus.fifo_dout[927:912]) | (|bus.fifo_dout[1023:960]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fmt_err <= 1'b0;
        else if (r_state == IDLE && start) r_fmt_err <= 1'b0;
        else if (r_rd_d && r_cap_cnt == 3'd6 && w_rsvd) r_fmt_err <= 1'b1;
    end
    assign fmt_err = r_fmt_err;
`else
    logic w_unused_rsvd;
    assign w_unused_rsvd = ^{bus.fifo_dout[895:480], bus.fifo_dout[927:912], bus.fifo_dout[1023:960]};
    assign fmt_err = 1'b0;
`endif

    assign bus.fifo_rd   = w_rd;
    assign bus.mb_valid  = (r_state == HOLD);
    assign done          = (r_state == DONE);
    assign bus.mb_x      = r_x;
    assign bus.mb_y      = r_y;
    assign bus.ac_levels = r_ac;
    assign bus.uv_levels = r_uv;
    assign bus.dc_levels = r_dc;
    assign bus.mode_i16  = r_i16;
    assign bus.mode_i4   = r_i4;
    assign bus.mode_uv   = r_muv;
    assign bus.nz        = r_nz;
    assign bus.mbtype    = r_type;
    assign bus.skipped   = r_skip;
    assign bus.max_edge  = r_edge;
endmodule

// File: tb/tb_mb_result_reader.sv
// tb_mb_result_reader: randomized scoreboard bench with a FIFO model and a frame-level reference model.
module tb_mb_result_reader;
    logic clk = 0;
    logic rst_n = 0;
    logic start = 0;
    logic [9:0] w1 = 0, h1 = 0;
    logic done, fmt_err;
    mb_result_reader_if bus();

    mb_result_reader dut (.clk(clk), .rst_n(rst_n), .start(start), .w1(w1), .h1(h1),
                          .bus(bus), .done(done), .fmt_err(fmt_err));

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]    x, y;
        logic [4095:0] ac;
        logic [2047:0] uv;
        logic [1023:0] w6;
    } rec_t;

    rec_t          exp_q[$];
    logic [1023:0] fq[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, rd_cnt = 0, hold = 0;
    int first_rd = -1, last_rd = -1, first_val = -1, hs_last = -10;
    int smode = 0, rmode = 0;
    bit tgl = 0, rd_pend = 0, done_prev = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic logic [31:0] fold(input logic [4095:0] v);
        logic [31:0] f = 0;
        for (int i = 0; i < 128; i++) f ^= v[i*32 +: 32];
        return f;
    endfunction

    function automatic logic [1023:0] rand_word();
        logic [1023:0] w;
        for (int i = 0; i < 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [575:0] w6_fields(input logic [1023:0] w);
        return {w[255:0], w[287:256], w[415:288], w[447:416], w[479:448], w[903:896], w[911:904], w[959:928]};
    endfunction

    // FIFO model: one-cycle read latency, optional forced-empty stalls.
    always @(posedge clk) begin
        logic [1023:0] w;
        bit pop;
        cyc++;
        pop = 0;
        if (rd_pend) begin
            if (fq.size() > 0) begin w = fq.pop_front(); pop = 1; end
            else chk(0, "pop_empty_fifo", 0, 1);
        end
        tgl = ~tgl;
        #1;
        if (pop) bus.fifo_dout = w;
        bus.fifo_empty = (fq.size() == 0) || (smode == 1 && tgl) || (smode == 2 && $urandom_range(0, 2) == 0);
    end

    always @(posedge clk) begin
        #1;
        if (hold > 0) begin bus.mb_ready = 0; hold--; end
        else bus.mb_ready = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Monitor: checks every presented record against the scoreboard head.
    always @(negedge clk) begin
        rec_t e;
        rd_pend = bus.fifo_rd;
        if (bus.fifo_rd) begin
            chk(!bus.fifo_empty, "rd_while_empty", 1, 0);
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (bus.mb_valid) begin
            if (first_val < 0) first_val = cyc;
            chk(!bus.fifo_rd, "rd_during_hold", 1, 0);
            if (exp_q.size() == 0) chk(0, "unexpected_valid", {bus.mb_x, bus.mb_y}, 0);
            else begin
                e = exp_q[0];
                chk({bus.mb_x, bus.mb_y} == {e.x, e.y}, "position", {bus.mb_x, bus.mb_y}, {e.x, e.y});
                chk(bus.ac_levels == e.ac, "ac_levels", fold(bus.ac_levels), fold(e.ac));
                chk(bus.uv_levels == e.uv, "uv_levels", fold({2048'd0, bus.uv_levels}), fold({2048'd0, e.uv}));
                chk({bus.dc_levels, bus.mode_i16, bus.mode_i4, bus.mode_uv, bus.nz, bus.mbtype, bus.skipped, bus.max_edge}
                    == w6_fields(e.w6), "beat6_fields",
                    fold({3520'd0, bus.dc_levels, bus.mode_i16, bus.mode_i4, bus.mode_uv, bus.nz, bus.mbtype, bus.skipped, bus.max_edge}),
                    fold({3520'd0, w6_fields(e.w6)}));
                if (bus.mb_ready) begin void'(exp_q.pop_front()); hs_last = cyc; end
            end
        end
        if (done) begin
            done_cnt++;
            chk(!done_prev, "done_width", 2, 1);
            chk(exp_q.size() == 0, "done_early", exp_q.size(), 0);
            chk(cyc == hs_last + 1, "done_latency", cyc - hs_last, 1);
        end
        done_prev = done;
    end

    task automatic chk_zero(input string nm);
        chk({bus.fifo_rd, bus.mb_valid, done, fmt_err, bus.mb_x, bus.mb_y} == 0, {nm, "_ctrl"},
            {bus.fifo_rd, bus.mb_valid, done, fmt_err, bus.mb_x, bus.mb_y}, 0);
        chk(bus.ac_levels == 0, {nm, "_ac"}, fold(bus.ac_levels), 0);
        chk(bus.uv_levels == 0, {nm, "_uv"}, fold({2048'd0, bus.uv_levels}), 0);
        chk({bus.dc_levels, bus.mode_i16, bus.mode_i4, bus.mode_uv, bus.nz, bus.mbtype, bus.skipped, bus.max_edge} == 0,
            {nm, "_fields"}, bus.max_edge, 0);
    endtask

    // kind: 0 random, 1 fixed beat-6 pattern, 2 reserved bit 500 set in the first record
    task automatic run_frame(input int fw, input int fh, input int sm, input int rm, input int hd, input int kind);
        rec_t r;
        logic [1023:0] w[7];
        bit exp_fmt;
        int d0;
        exp_fmt = 0;
        for (int y = 0; y <= fh; y++)
            for (int x = 0; x <= fw; x++) begin
                for (int b = 0; b < 7; b++) w[b] = rand_word();
                w[6][895:480] = '0;
                w[6][927:912] = '0;
                w[6][1023:960] = '0;
                if (kind == 1) begin
                    w[6] = '0;
                    w[6][255:0] = 256'h1;
                    w[6][903:896] = 8'h1;
                    w[6][959:928] = 32'h55;
                end
                if (kind == 2 && x == 0 && y == 0) begin w[6][500] = 1'b1; exp_fmt = 1; end
                for (int b = 0; b < 7; b++) fq.push_back(w[b]);
                r.x = 10'(x);
                r.y = 10'(y);
                r.ac = {w[3], w[2], w[1], w[0]};
                r.uv = {w[5], w[4]};
                r.w6 = w[6];
                exp_q.push_back(r);
            end
`ifndef MB_RESULT_READER_FMT_CHECK_EN
        exp_fmt = 0;
`endif
        smode = sm;
        rmode = rm;
        @(posedge clk);
        #2;
        hold = hd;
        first_rd = -1; first_val = -1; rd_cnt = 0;
        d0 = done_cnt;
        start = 1; w1 = 10'(fw); h1 = 10'(fh);
        @(posedge clk);
        #2 start = 0;
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clk);
        chk(done_cnt == d0 + 1, "frame_done", done_cnt - d0, 1);
        repeat (3) @(negedge clk);
        chk(done_cnt == d0 + 1, "single_done", done_cnt - d0, 1);
        chk(exp_q.size() == 0 && fq.size() == 0, "all_consumed", {exp_q.size(), fq.size()}, 0);
        chk(fmt_err == exp_fmt, "fmt_err", fmt_err, exp_fmt);
        exp_q.delete();
        fq.delete();
    endtask

    initial begin
        bus.fifo_empty = 1;
        bus.fifo_dout = '0;
        bus.mb_ready = 0;
        #23;
        chk_zero("reset_state");
        @(posedge clk);
        #2 rst_n = 1;
        run_frame(0, 0, 0, 0, 0, 1);
        chk(first_val - first_rd == 8, "first_valid_latency", first_val - first_rd, 8);
        chk(rd_cnt == 7 && last_rd - first_rd == 6, "seven_back_to_back_reads", {rd_cnt, last_rd - first_rd}, {32'd7, 32'd6});
        run_frame(1, 1, 0, 0, 0, 0);
        run_frame(1, 0, 1, 0, 0, 0);
        run_frame(1, 0, 0, 0, 30, 0);
        run_frame(0, 0, 0, 0, 0, 2);
        run_frame(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++)
            run_frame($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), 0, 0);
        // Abort a record after three captured beats.
        smode = 0;
        for (int b = 0; b < 3; b++) fq.push_back(rand_word());
        @(posedge clk);
        #2 start = 1; w1 = 0; h1 = 0;
        @(posedge clk);
        #2 start = 0;
        repeat (10) @(posedge clk);
        #2 rst_n = 0;
        #1 chk_zero("async_reset");
        fq.delete();
        @(posedge clk);
        #2 rst_n = 1;
        for (int b = 0; b < 7; b++) fq.push_back(rand_word());
        rd_cnt = 0;
        repeat (10) @(negedge clk);
        chk(rd_cnt == 0, "no_rd_after_reset", rd_cnt, 0);
        fq.delete();
        repeat (2) @(posedge clk);
        run_frame(1, 0, 2, 1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected 0", cyc);
        $fatal(1, "timeout");
    end
endmodule
